uart_tx_shifter: RTL and testbench
==================================

# uart_tx_shifter

Serial transmit datapath of the UART. It sits directly downstream of the baud/bit timing counter and consumes that block's one-cycle bit strobe. It buffers one byte from the CPU-side write port in a holding register, frames it (start, data LSB-first, optional parity, stop), and drives the TxD line one bit per strobe. Double buffering, with a holding register plus a shift register, allows back-to-back frames with no idle bit between them.

## Interface
- DATA_BITS, 8, data bits per frame (5–8)
- PARITY_EN, 0, 1 inserts a parity bit after the data bits
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even (ignored when PARITY_EN=0)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- clock  in  1  system clock, 50 MHz
- reset  in  1  reset, synchronous, active-high
- bit_tick  in  1  one-cycle strobe, one per bit period (nominally every 1303 clocks)
- xmit_go  in  1  write strobe; loads tx_data into the holding register
- tx_data  in  DATA_BITS  byte to transmit
- tx_empty  out  1  holding register empty, write may be accepted
- tx_idle  out  1  shifter idle and line at mark (holding register may still be full)
- tx_overrun  out  1  one-cycle pulse when xmit_go arrives with tx_empty=0
- txd  out  1  serial line, idle high

## Operation
- Reset values: txd=1, tx_empty=1, tx_idle=1, tx_overrun=0, state TX_IDLE, holding and shift registers cleared.
- Write: at a clock edge with xmit_go=1 and tx_empty=1, tx_data is captured and tx_empty=0 from the next cycle.
- If xmit_go=1 while tx_empty=0, the data is dropped, the holding register is unchanged, and tx_overrun=1 for exactly one cycle.
- FSM states are TX_IDLE, TX_START, TX_DATA, TX_PARITY and TX_STOP. All state changes occur only on cycles with bit_tick=1.
- TX_IDLE, bit_tick with holding full: move holding to the shift register, set tx_empty=1 and tx_idle=0, go to TX_START, txd=0.
- TX_IDLE, bit_tick with holding empty: remain in TX_IDLE, txd=1.
- TX_START, bit_tick: go to TX_DATA and drive shift bit 0.
- TX_DATA: each bit_tick shifts right. After DATA_BITS bits, go to TX_PARITY if PARITY_EN=1, otherwise TX_STOP.
- Parity bit = XOR of data bits, inverted if PARITY_ODD=1. It is computed at transfer time from the captured byte.
- TX_STOP: txd=1 for STOP_BITS ticks. On the final stop tick, if the holding register is full, transfer it and go directly to TX_START (back-to-back frame). Otherwise go to TX_IDLE with tx_idle=1.
- Frame length with the default parameters is 10 bit periods.
- Simultaneous xmit_go and bit_tick in TX_IDLE with holding empty: the byte is captured, but transfer waits for the next bit_tick.
- Simultaneous xmit_go and transfer: tx_empty is still 0 at that edge, so the write is rejected with an overrun pulse.
- Reset mid-frame: txd returns to 1 the next cycle, any frame in flight is abandoned, and the holding contents are discarded.

## Timing
- txd, tx_empty, tx_idle and tx_overrun are registered outputs with no combinational path from inputs.
- Latency from accepted xmit_go to the txd falling edge is 1 clock after the next bit_tick; worst case is one bit period plus 1 clock.
- Each txd bit changes exactly 1 clock after its bit_tick and is held until 1 clock after the following bit_tick.
- tx_empty rises 1 clock after the transfer tick, so a new byte can be written during a frame.
- bit_tick may be asserted on consecutive cycles; every strobe is honoured.

## Structure
- Shared package uart_pkg contains:
  - typedef enum tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}
  - localparam BAUD_DIV=1302
  - function frame_bits(DATA_BITS, PARITY_EN, STOP_BITS)
- Single flat module. The holding register, shift register, bit counter (clog2 of DATA_BITS) and stop counter are all internal. No sub-module is needed.

## Test plan
- Default params, bit_tick every 4 clocks, xmit_go with 0x55: txd sequence 0,1,0,1,0,1,0,1,0,1, each held 4 clocks, then idle high; tx_idle=1 after the final stop tick.
- Write 0xA3, then write 0x0F while the 0xA3 frame is in progress: two frames with no idle bit between them; the 0x0F start bit immediately follows the 0xA3 stop bit.
- Two xmit_go with tx_empty=0 (0x11 accepted, 0x22 issued before transfer): tx_overrun pulses once, and only 0x11 appears on txd.
- PARITY_EN=1, PARITY_ODD=0, data 0x07: parity bit 1, 11-bit frame. With PARITY_ODD=1: parity bit 0.
- Assert reset during data bit 3 of a 0xF0 frame: txd=1, tx_empty=1 and tx_idle=1 on the next clock, and no further low bits appear.
- Issue xmit_go in the same cycle as bit_tick while idle: txd stays high until the next bit_tick, then the start bit follows 1 clock later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, nominal baud divider and frame sizing.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   // 50 MHz / 38400 baud, counted 0..BAUD_DIV by the bit timing block
   localparam int BAUD_DIV = 1302;

   function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
      return 1 + data_bits + ((parity_en != 0) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// UART transmit datapath: holding register plus shift register, framed onto txd one bit per bit_tick.
//
// state     | meaning
// TX_IDLE   | line at mark, waiting for a tick with the holding register full
// TX_START  | start bit (0) on the line
// TX_DATA   | data bits on the line, LSB first
// TX_PARITY | parity bit on the line
// TX_STOP   | stop bit(s) (1) on the line; last one may chain straight into the next frame
module uart_tx_shifter
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 bit_tick,
   input  logic                 xmit_go,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_empty,
   output logic                 tx_idle,
   output logic                 tx_overrun,
   output logic                 txd
);

   localparam int                CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic              ODD       = 1'(PARITY_ODD);

   tx_state_t            state, state_n;
   logic [DATA_BITS-1:0] hold, hold_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
   logic                 stop_cnt, stop_cnt_n;
   logic                 par, par_n;
   logic                 txd_n, empty_n, idle_n, overrun_n;
   logic                 load;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= TX_IDLE;
         hold       <= '0;
         shift      <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         par        <= 1'b0;
         txd        <= 1'b1;
         tx_empty   <= 1'b1;
         tx_idle    <= 1'b1;
         tx_overrun <= 1'b0;
      end else begin
         state      <= state_n;
         hold       <= hold_n;
         shift      <= shift_n;
         bit_cnt    <= bit_cnt_n;
         stop_cnt   <= stop_cnt_n;
         par        <= par_n;
         txd        <= txd_n;
         tx_empty   <= empty_n;
         tx_idle    <= idle_n;
         tx_overrun <= overrun_n;
      end
   end

   always_comb begin
      state_n    = state;
      hold_n     = hold;
      shift_n    = shift;
      bit_cnt_n  = bit_cnt;
      stop_cnt_n = stop_cnt;
      par_n      = par;
      txd_n      = txd;
      empty_n    = tx_empty;
      idle_n     = tx_idle;
      overrun_n  = 1'b0;
      load       = 1'b0;

      // A write and a transfer can never both act: one needs tx_empty=1, the other tx_empty=0.
      if (xmit_go) begin
         if (tx_empty) begin
            hold_n  = tx_data;
            empty_n = 1'b0;
         end else begin
            overrun_n = 1'b1;
         end
      end

      if (bit_tick) begin
         case (state)
            TX_IDLE: begin
               if (!tx_empty) load = 1'b1;
               else           txd_n = 1'b1;
            end
            TX_START: begin
               txd_n     = shift[0];
               shift_n   = shift >> 1;
               bit_cnt_n = '0;
               state_n   = TX_DATA;
            end
            TX_DATA: begin
               if (bit_cnt == LAST_BIT) begin
                  stop_cnt_n = 1'b0;
                  if (PARITY_EN != 0) begin
                     state_n = TX_PARITY;
                     txd_n   = par;
                  end else begin
                     state_n = TX_STOP;
                     txd_n   = 1'b1;
                  end
               end else begin
                  txd_n     = shift[0];
                  shift_n   = shift >> 1;
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
            TX_PARITY: begin
               state_n    = TX_STOP;
               txd_n      = 1'b1;
               stop_cnt_n = 1'b0;
            end
            TX_STOP: begin
               if (stop_cnt == LAST_STOP) begin
                  if (!tx_empty) begin
                     load = 1'b1;
                  end else begin
                     state_n = TX_IDLE;
                     idle_n  = 1'b1;
                     txd_n   = 1'b1;
                  end
               end else begin
                  stop_cnt_n = stop_cnt + 1'b1;
               end
            end
            default: state_n = TX_IDLE;
         endcase
      end

      if (load) begin
         shift_n = hold;
         par_n   = (^hold) ^ ODD;
         empty_n = 1'b1;
         idle_n  = 1'b0;
         txd_n   = 1'b0;
         state_n = TX_START;
      end
   end

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Bench for uart_tx_shifter: four parameter variants driven in parallel, checked every cycle
// against a frame-vector model, plus literal line/flag expectations at chosen points.
module tb_uart_tx_shifter;
   import uart_pkg::*;

   logic       clock = 1'b0;
   logic       reset, bit_tick, xmit_go;
   logic [7:0] tx_data;
   logic [3:0] d_txd, d_empty, d_idle, d_ovr;

   always #5 clock = ~clock;

   uart_tx_shifter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clock(clock), .reset(reset), .bit_tick(bit_tick), .xmit_go(xmit_go), .tx_data(tx_data),
      .tx_empty(d_empty[0]), .tx_idle(d_idle[0]), .tx_overrun(d_ovr[0]), .txd(d_txd[0]));
   uart_tx_shifter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
      .clock(clock), .reset(reset), .bit_tick(bit_tick), .xmit_go(xmit_go), .tx_data(tx_data),
      .tx_empty(d_empty[1]), .tx_idle(d_idle[1]), .tx_overrun(d_ovr[1]), .txd(d_txd[1]));
   uart_tx_shifter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
      .clock(clock), .reset(reset), .bit_tick(bit_tick), .xmit_go(xmit_go), .tx_data(tx_data),
      .tx_empty(d_empty[2]), .tx_idle(d_idle[2]), .tx_overrun(d_ovr[2]), .txd(d_txd[2]));
   uart_tx_shifter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
      .clock(clock), .reset(reset), .bit_tick(bit_tick), .xmit_go(xmit_go), .tx_data(tx_data),
      .tx_empty(d_empty[3]), .tx_idle(d_idle[3]), .tx_overrun(d_ovr[3]), .txd(d_txd[3]));

   localparam int PE[4] = '{0, 1, 1, 0};
   localparam int PO[4] = '{0, 0, 1, 0};
   localparam int SB[4] = '{1, 1, 1, 2};

   // Model: a frame is a vector of line levels popped one per tick; holding is a byte plus a full flag.
   typedef struct packed {
      logic [15:0] fr;
      logic [4:0]  rem;
      logic [7:0]  hold;
      logic        full;
      logic        txd;
      logic        idle;
      logic        ovr;
   } mstate_t;

   mstate_t m[4];
   logic    m_started = 1'b0;

   function automatic mstate_t model_next(input mstate_t s, input int k, input logic rst,
                                          input logic tick, input logic go, input logic [7:0] d);
      mstate_t     n = s;
      logic [15:0] f;
      if (rst) begin
         n      = '0;
         n.txd  = 1'b1;
         n.idle = 1'b1;
         return n;
      end
      n.ovr = go && s.full;
      if (tick) begin
         if (s.rem != 0) begin
            n.txd = s.fr[0];
            n.fr  = s.fr >> 1;
            n.rem = s.rem - 5'd1;
         end else if (s.full) begin
            f      = '1;
            f[0]   = 1'b0;
            f[8:1] = s.hold;
            if (PE[k] != 0) f[9] = (^s.hold) ^ (PO[k] != 0);
            n.txd  = 1'b0;
            n.fr   = f >> 1;
            n.rem  = 5'(frame_bits(8, PE[k], SB[k]) - 1);
            n.full = 1'b0;
            n.idle = 1'b0;
         end else begin
            n.txd  = 1'b1;
            n.idle = 1'b1;
         end
      end
      if (go && !s.full) begin
         n.hold = d;
         n.full = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clock) begin
      m_started <= 1'b1;
      for (int k = 0; k < 4; k++)
         m[k] <= model_next(m[k], k, reset, bit_tick, xmit_go, tx_data);
   end

   int    n_cmp = 0;
   int    n_bad = 0;
   logic  lit_on = 1'b0;
   int    lit_kind = 0;
   int    lit_inst = 0;
   logic  lit_val = 1'b0;
   string lit_name = "";

   task automatic chk(input string nm, input int k, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d @%0t: got %b expected %b", nm, k, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (m_started) begin
         for (int k = 0; k < 4; k++) begin
            chk("txd",        k, d_txd[k],   m[k].txd);
            chk("tx_empty",   k, d_empty[k], !m[k].full);
            chk("tx_idle",    k, d_idle[k],  m[k].idle);
            chk("tx_overrun", k, d_ovr[k],   m[k].ovr);
         end
         if (lit_on) begin
            case (lit_kind)
               0: chk({"lit_txd_", lit_name},   lit_inst, d_txd[lit_inst],   lit_val);
               1: chk({"lit_empty_", lit_name}, lit_inst, d_empty[lit_inst], lit_val);
               2: chk({"lit_idle_", lit_name},  lit_inst, d_idle[lit_inst],  lit_val);
               3: chk({"lit_ovr_", lit_name},   lit_inst, d_ovr[lit_inst],   lit_val);
               default: begin
                  chk({"lit_rst_txd_", lit_name},   lit_inst, d_txd[lit_inst],   1'b1);
                  chk({"lit_rst_empty_", lit_name}, lit_inst, d_empty[lit_inst], 1'b1);
                  chk({"lit_rst_idle_", lit_name},  lit_inst, d_idle[lit_inst],  1'b1);
                  chk({"lit_rst_ovr_", lit_name},   lit_inst, d_ovr[lit_inst],   1'b0);
               end
            endcase
         end
      end
   end

   // Inputs change 2 ns after the rising edge; checks happen on the falling edge.
   task automatic step();
      @(posedge clock);
      #2;
      lit_on = 1'b0;
   endtask

   task automatic expect_lit(input int kind, input int inst, input logic val, input string nm);
      lit_kind = kind;
      lit_inst = inst;
      lit_val  = val;
      lit_name = nm;
      lit_on   = 1'b1;
   endtask

   task automatic write(input logic [7:0] d);
      step();
      xmit_go = 1'b1;
      tx_data = d;
      step();
      xmit_go = 1'b0;
   endtask

   task automatic tick();
      step();
      bit_tick = 1'b1;
      step();
      bit_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         repeat (2) step();
      end
   endtask

   task automatic ticks_lit(input int inst, input int n, input logic [31:0] exp, input string nm);
      for (int i = 0; i < n; i++) begin
         tick();
         expect_lit(0, inst, exp[i], nm);
         repeat (2) step();
      end
   endtask

   logic [31:0] bb;

   initial begin
      reset    = 1'b1;
      bit_tick = 1'b0;
      xmit_go  = 1'b0;
      tx_data  = 8'h00;
      repeat (3) step();
      reset = 1'b0;
      expect_lit(4, 0, 1'b1, "por");
      step();

      write(8'h55);
      expect_lit(1, 0, 1'b0, "after_write");
      ticks_lit(0, 10, 32'b1010101010, "f55");
      tick();
      expect_lit(2, 0, 1'b1, "f55_done");
      repeat (2) step();
      ticks(2);

      bb = {12'b0, 10'b1000011110, 10'b1101000110};
      write(8'hA3);
      ticks_lit(0, 1, 32'b0, "a3_start");
      write(8'h0F);
      ticks_lit(0, 19, bb >> 1, "a3_0f");
      tick();
      expect_lit(2, 0, 1'b1, "a3_0f_done");
      repeat (2) step();
      ticks(3);

      write(8'h11);
      write(8'h22);
      expect_lit(3, 0, 1'b1, "ovr_pulse");
      step();
      expect_lit(3, 0, 1'b0, "ovr_clear");
      ticks_lit(0, 10, 32'b1000100010, "f11");
      ticks(3);

      write(8'h07);
      ticks_lit(1, 11, 32'b11000001110, "par_even");
      ticks(2);
      write(8'h07);
      ticks_lit(2, 11, 32'b10000001110, "par_odd");
      ticks(2);

      write(8'hF0);
      ticks_lit(0, 5, 32'b00000, "f0_head");
      write(8'h3C);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      expect_lit(4, 0, 1'b1, "mid_frame");
      step();
      ticks_lit(0, 4, 32'b1111, "after_reset");

      step();
      xmit_go  = 1'b1;
      bit_tick = 1'b1;
      tx_data  = 8'h5A;
      step();
      xmit_go  = 1'b0;
      bit_tick = 1'b0;
      expect_lit(0, 0, 1'b1, "go_tick_same");
      step();
      expect_lit(1, 0, 1'b0, "go_tick_held");
      step();
      ticks_lit(0, 10, 32'b1010110100, "f5a");
      ticks(3);

      write(8'h33);
      step();
      xmit_go  = 1'b1;
      bit_tick = 1'b1;
      tx_data  = 8'h44;
      step();
      xmit_go  = 1'b0;
      bit_tick = 1'b0;
      expect_lit(3, 0, 1'b1, "ovr_at_xfer");
      repeat (2) step();
      ticks_lit(0, 9, 32'b100110011, "f33");
      tick();
      expect_lit(2, 0, 1'b1, "f33_done");
      repeat (2) step();
      ticks_lit(0, 3, 32'b111, "no_44");

      write(8'h96);
      step();
      bit_tick = 1'b1;
      repeat (13) step();
      bit_tick = 1'b0;
      expect_lit(2, 3, 1'b1, "burst_done");
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
